nn_frame_sequencer: RTL

Upstream feeder for the perceptron network. It accepts one frame of bytes over a valid/ready stream: 24 parameter bytes followed by 4 input bytes. It buffers the whole frame, then replays it to the network one byte per clock on the network's `data_in`. It also generates the single-cycle `changes` pulses that step the network's 4-phase machine: parameters → inputs → compute → result → back to parameters.

---
 rtl/nn_frame_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/nn_frame_sequencer.sv
// Frame buffer and step-pulse generator feeding the perceptron network.
// Accepts PARAM_BYTES + INPUT_BYTES bytes over valid/ready, then replays them
// one byte per clock while stepping the network's 4-phase machine with
// single-cycle nn_changes pulses. All outputs are registered.
module nn_frame_sequencer #(
  parameter int unsigned PARAM_BYTES    = 24,
  parameter int unsigned INPUT_BYTES    = 4,
  parameter int unsigned COMPUTE_CYCLES = 2,
  parameter int unsigned RESULT_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] nn_data,
  output logic       nn_data_valid,
  output logic       nn_changes,
  output logic [1:0] nn_phase,
  output logic       result_valid,
  output logic       frame_done
);

  localparam int unsigned FrameBytes = PARAM_BYTES + INPUT_BYTES;
  // 6-bit indices cover frames up to 63 bytes; widen only when the frame needs it.
  localparam int unsigned IdxW       = (FrameBytes > 63) ? 7 : 6;
  localparam int unsigned AddrW      = $clog2(FrameBytes);

  localparam logic [IdxW-1:0] FrameLen    = IdxW'(FrameBytes);
  localparam logic [IdxW-1:0] FrameLast   = IdxW'(FrameBytes - 1);
  localparam logic [IdxW-1:0] ParamLast   = IdxW'(PARAM_BYTES - 1);
  localparam logic [7:0]      ComputeLast = 8'(COMPUTE_CYCLES - 1);
  localparam logic [7:0]      ResultLast  = 8'(RESULT_CYCLES - 1);

  typedef enum logic [3:0] {
    StFill,
    StParam,
    StChg0,
    StInput,
    StChg1,
    StCompute,
    StChg2,
    StResult,
    StChg3
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] widx_q, widx_d;
  logic [IdxW-1:0] ridx_q, ridx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            wr_en;
  logic [7:0]      rd_data;
  logic [7:0]      mem_q [FrameBytes];

  logic       s_ready_q, s_ready_d;
  logic [7:0] nn_data_q, nn_data_d;
  logic       nn_data_valid_q, nn_data_valid_d;
  logic       nn_changes_q, nn_changes_d;
  logic [1:0] nn_phase_q, nn_phase_d;
  logic       result_valid_q, result_valid_d;
  logic       frame_done_q, frame_done_d;

  // Sequencing: state transitions and index/phase counter updates.
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    ridx_d  = ridx_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StFill: begin
        if (s_valid && s_ready_q) begin
          wr_en  = 1'b1;
          widx_d = widx_q + 1'b1;
          if (widx_q == FrameLast) begin
            state_d = StParam;
            ridx_d  = '0;
          end
        end
      end
      StParam: begin
        if (ridx_q == ParamLast) state_d = StChg0;
        else                     ridx_d  = ridx_q + 1'b1;
      end
      StChg0: begin
        state_d = StInput;
        ridx_d  = ridx_q + 1'b1;
      end
      StInput: begin
        if (ridx_q == FrameLast) state_d = StChg1;
        else                     ridx_d  = ridx_q + 1'b1;
      end
      StChg1: begin
        state_d = StCompute;
        cnt_d   = '0;
      end
      StCompute: begin
        if (cnt_q == ComputeLast) state_d = StChg2;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      StChg2: begin
        state_d = StResult;
        cnt_d   = '0;
      end
      StResult: begin
        if (cnt_q == ResultLast) state_d = StChg3;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      StChg3: begin
        state_d = StFill;
        widx_d  = '0;
        ridx_d  = '0;
      end
      default: state_d = StFill;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  // The FILL->PARAM edge reads entry 0 while entry F-1 is written; F >= 2 so
  // these never collide.
  always_comb begin
    s_ready_d       = 1'b0;
    nn_data_d       = 8'h00;
    nn_data_valid_d = 1'b0;
    nn_changes_d    = 1'b0;
    nn_phase_d      = 2'd0;
    result_valid_d  = 1'b0;
    frame_done_d    = 1'b0;
    rd_data         = mem_q[ridx_d[AddrW-1:0]];
    unique case (state_d)
      StFill:    s_ready_d = (widx_d < FrameLen);
      StParam: begin
        nn_data_d       = rd_data;
        nn_data_valid_d = 1'b1;
      end
      StChg0:    nn_changes_d = 1'b1;
      StInput: begin
        nn_data_d       = rd_data;
        nn_data_valid_d = 1'b1;
        nn_phase_d      = 2'd1;
      end
      StChg1: begin
        nn_changes_d = 1'b1;
        nn_phase_d   = 2'd1;
      end
      StCompute: nn_phase_d = 2'd2;
      StChg2: begin
        nn_changes_d = 1'b1;
        nn_phase_d   = 2'd2;
      end
      StResult: begin
        result_valid_d = 1'b1;
        nn_phase_d     = 2'd3;
      end
      StChg3: begin
        nn_changes_d = 1'b1;
        frame_done_d = 1'b1;
        nn_phase_d   = 2'd3;
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs; reset aborts any sequence at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= StFill;
      widx_q          <= '0;
      ridx_q          <= '0;
      cnt_q           <= '0;
      s_ready_q       <= 1'b0;
      nn_data_q       <= 8'h00;
      nn_data_valid_q <= 1'b0;
      nn_changes_q    <= 1'b0;
      nn_phase_q      <= 2'd0;
      result_valid_q  <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      widx_q          <= widx_d;
      ridx_q          <= ridx_d;
      cnt_q           <= cnt_d;
      s_ready_q       <= s_ready_d;
      nn_data_q       <= nn_data_d;
      nn_data_valid_q <= nn_data_valid_d;
      nn_changes_q    <= nn_changes_d;
      nn_phase_q      <= nn_phase_d;
      result_valid_q  <= result_valid_d;
      frame_done_q    <= frame_done_d;
    end
  end

  // Frame buffer: contents persist across frames and reset; only accepts write it.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[widx_q[AddrW-1:0]] <= s_data;
  end

  assign s_ready       = s_ready_q;
  assign nn_data       = nn_data_q;
  assign nn_data_valid = nn_data_valid_q;
  assign nn_changes    = nn_changes_q;
  assign nn_phase      = nn_phase_q;
  assign result_valid  = result_valid_q;
  assign frame_done    = frame_done_q;

endmodule
